alu_dispatch_queue: RTL
=======================

Name: alu_dispatch_queue

Overview:
In-order 2-wide buffer between decode/rename and the ALU reservation-station array. Accepts up to 2 ALU ops per cycle from rename. Hands up to 2 oldest ops per cycle to the RS array, limited by the RS free count. Snoops both CDB ports so queued source operands wake up while waiting.

Parameters:
DEPTH, 8, queue entries; power of 2, >= 4
TAG_W, 6, physical/ROB tag width; must match shared package

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush (mispredict/exception)
cache_stall  in  1  freeze enqueue and dequeue
dq_entry[1:0]  in  instruction_t  ops from rename; [0] older
dq_rdy  out  2  free slots, capped: 0, 1 or 2
rs_entry[1:0]  out  instruction_t  ops to RS array; [0] older
rs_rdy  in  2  RS free count; 0, 1, 2+ (2'b10/2'b11 both mean 2)
cdb_port0  in  writeback_packet_t  CDB broadcast 0
cdb_port1  in  writeback_packet_t  CDB broadcast 1

Behaviour:
- Storage: circular array of DEPTH instruction_t. head/tail are log2(DEPTH)+1 bits, with the extra bit as wrap flag. count = tail-head.
- Full: count==DEPTH. Empty: count==0.
- dq_rdy = min(DEPTH-count, 2), computed from registered count at start of cycle.
- Enqueue, when !flush && !cache_stall:
  - Valid dq_entry slots are compacted in order, [0] before [1], and written at tail, tail+1 (mod DEPTH).
  - tail advances by number written.
  - Upstream never presents more valid ops than dq_rdy; excess entries are not written.
  - Full plus simultaneous dequeue still gives dq_rdy=0; no same-cycle reuse of freed slots.
- Dequeue:
  - n_deq = min(count, rs_rdy_eff), or 0 if flush or cache_stall.
  - rs_entry[k] = entry[head+k] with valid = (k < n_deq); outputs are combinational from storage.
  - head advances by n_deq at clock edge. The RS array writes rs_entry that same edge.
- Latency: op enqueued at edge N is visible on rs_entry from cycle N+1. No enqueue-to-dequeue bypass.
- CDB snoop: applies to every occupied entry and every entry being enqueued.
  - For src1/src2 with rdy=0: if cdb_portX.valid and cdb_portX.tag==src_tag, set rdy=1 and data=cdb_portX.data at the edge.
  - Port0 has priority if both ports match.
  - Same match is forwarded combinationally onto rs_entry operand fields, so an op dequeued in the broadcast cycle carries the value.
- cache_stall: no enqueue, no dequeue (rs_entry valid=0), snoop continues.
- flush: head=tail=0 and all entry valid bits cleared at the edge. rs_entry valid forced 0 that cycle. Enqueue ignored. flush overrides cache_stall.
- Reset (rst=1 at edge): same state as flush.
  - Reset-state outputs: dq_rdy=2, rs_entry[*].valid=0.
  - Reset mid-operation discards all contents.
- Wrap-around: 2-entry writes/reads may span index DEPTH-1 -> 0.

Optional Feature:
DQ_PERF_CNT_EN
- Defined: adds outputs perf_full_cycles[31:0] and perf_rs_block_cycles[31:0].
  - perf_full_cycles counts cycles with count==DEPTH.
  - perf_rs_block_cycles counts cycles with count>0, rs_rdy==0, !cache_stall.
  - Both saturate at 32'hFFFFFFFF and clear on rst (not flush).
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Shared package (riscv_pkg) holds:
  - instruction_t: valid, src1_rdy/tag/data, src2_rdy/tag/data, dest_tag, op fields.
  - writeback_packet_t: valid, tag, data.
  - TAG_W and DQ_DEPTH.
- One sub-module, cdb_snoop: combinational per-operand match of (rdy, tag, data) against both CDB ports, returning updated (rdy, data) with port0 priority. Instantiated per stored operand and per output operand.

Test Plan:
- Reset, then enqueue 2 valid ops (tags 3,4) with rs_rdy=2 -> next cycle rs_entry[0].dest_tag=3, [1]=4, both valid; dq_rdy=2 throughout.
- Fill 8 entries with rs_rdy=0 -> dq_rdy 2,2,2,2,0; perf_full_cycles increments while full. Then rs_rdy=1 -> one op per cycle drains in order; dq_rdy=1 after first dequeue.
- Queued op with src1_rdy=0, src1_tag=5; cdb_port1 valid tag=5 data=32'hDEAD in its dequeue cycle -> rs_entry[0].src1_rdy=1, data=32'hDEAD same cycle.
- Both CDB ports match tag 7 (data A on port0, B on port1) -> stored operand takes A.
- Pointers at head=6 with 4 entries, rs_rdy=2 -> dequeues indices 6,7 then 0,1, order preserved.
- Flush asserted with 5 queued entries, cache_stall=1 and 2 valid enqueue inputs -> rs_entry valid 0. Next cycle count=0, dq_rdy=2, nothing issued.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the ALU dispatch path: instruction and CDB writeback payloads.
package riscv_pkg;

    localparam int unsigned TAG_W    = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned DQ_DEPTH = 8;

    typedef struct packed {
        logic              valid;
        logic              src1_rdy;
        logic [TAG_W-1:0]  src1_tag;
        logic [DATA_W-1:0] src1_data;
        logic              src2_rdy;
        logic [TAG_W-1:0]  src2_tag;
        logic [DATA_W-1:0] src2_data;
        logic [TAG_W-1:0]  dest_tag;
        logic [OP_W-1:0]   alu_op;
    } instruction_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } writeback_packet_t;

    // RS free count saturates at 2: 2'b10 and 2'b11 both mean two slots.
    function automatic logic [1:0] rs_rdy_eff(input logic [1:0] rs_rdy);
        return rs_rdy[1] ? 2'd2 : rs_rdy;
    endfunction

endpackage

// File: rtl/cdb_snoop.sv
// Single-operand CDB wakeup: matches a waiting source tag against both
// broadcast ports, port 0 winning when both hit.
module cdb_snoop
    import riscv_pkg::*;
(
    input  logic              i_rdy,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [DATA_W-1:0] i_data,
    input  writeback_packet_t i_cdb0,
    input  writeback_packet_t i_cdb1,
    output logic              o_rdy,
    output logic [DATA_W-1:0] o_data
);

    logic w_hit0;
    logic w_hit1;

    assign w_hit0 = !i_rdy && i_cdb0.valid && (i_cdb0.tag == i_tag);
    assign w_hit1 = !i_rdy && i_cdb1.valid && (i_cdb1.tag == i_tag);

    // Wake the operand from the highest-priority matching port.
    always_comb begin
        o_rdy  = i_rdy;
        o_data = i_data;
        if (w_hit0) begin
            o_rdy  = 1'b1;
            o_data = i_cdb0.data;
        end else if (w_hit1) begin
            o_rdy  = 1'b1;
            o_data = i_cdb1.data;
        end
    end

endmodule

// File: rtl/alu_dispatch_queue.sv
// In-order 2-wide dispatch queue between rename and the ALU RS array.
// Optional build macro DQ_PERF_CNT_EN adds saturating full / RS-blocked
// cycle counters.
module alu_dispatch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = DQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cache_stall,
    input  instruction_t      dq_entry [1:0],
    output logic [1:0]        dq_rdy,
    output instruction_t      rs_entry [1:0],
    input  logic [1:0]        rs_rdy,
    input  writeback_packet_t cdb_port0,
    input  writeback_packet_t cdb_port1
`ifdef DQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_full_cycles,
    output logic [31:0]       perf_rs_block_cycles
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]  r_head;
    logic [CNT_W-1:0]  r_tail;
    instruction_t      r_mem [DEPTH];

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic              w_hold;
    logic [1:0]        w_rs_eff;
    logic [1:0]        w_n_deq;
    logic [1:0]        w_enq_num;
    logic [PTR_W-1:0]  w_rd_idx0;
    logic [PTR_W-1:0]  w_rd_idx1;
    logic [PTR_W-1:0]  w_wr_idx0;
    logic [PTR_W-1:0]  w_wr_idx1;

    instruction_t      w_snp_mem [DEPTH];
    logic              w_m_s1_rdy  [DEPTH];
    logic [DATA_W-1:0] w_m_s1_data [DEPTH];
    logic              w_m_s2_rdy  [DEPTH];
    logic [DATA_W-1:0] w_m_s2_data [DEPTH];

    instruction_t      w_enq_raw [2];
    instruction_t      w_enq_snp [2];
    logic              w_e_s1_rdy  [2];
    logic [DATA_W-1:0] w_e_s1_data [2];
    logic              w_e_s2_rdy  [2];
    logic [DATA_W-1:0] w_e_s2_data [2];

    assign w_count   = r_tail - r_head;
    assign w_free    = CNT_W'(DEPTH) - w_count;
    assign w_hold    = rst || flush || cache_stall;
    assign w_rs_eff  = rs_rdy_eff(rs_rdy);
    assign w_rd_idx0 = r_head[PTR_W-1:0];
    assign w_rd_idx1 = w_rd_idx0 + PTR_W'(1);
    assign w_wr_idx0 = r_tail[PTR_W-1:0];
    assign w_wr_idx1 = w_wr_idx0 + PTR_W'(1);

    // Free-slot credit to rename, from the registered occupancy only.
    always_comb begin
        dq_rdy = (w_free >= CNT_W'(2)) ? 2'd2 : w_free[1:0];
    end

    // Number of ops handed to the RS array this cycle.
    always_comb begin
        w_n_deq = 2'd0;
        if (!w_hold) begin
            if (w_count >= CNT_W'(w_rs_eff)) begin
                w_n_deq = w_rs_eff;
            end else begin
                w_n_deq = w_count[1:0];
            end
        end
    end

    // Compact valid rename slots in age order and cap them at the credit.
    always_comb begin
        w_enq_raw[0] = dq_entry[0];
        w_enq_raw[1] = dq_entry[1];
        w_enq_num    = 2'd0;
        if (dq_entry[0].valid) begin
            if (dq_entry[1].valid) begin
                w_enq_num = dq_rdy;
            end else begin
                w_enq_num = (dq_rdy != 2'd0) ? 2'd1 : 2'd0;
            end
        end else if (dq_entry[1].valid) begin
            w_enq_raw[0] = dq_entry[1];
            w_enq_num    = (dq_rdy != 2'd0) ? 2'd1 : 2'd0;
        end
        if (w_hold) begin
            w_enq_num = 2'd0;
        end
    end

    // Wakeup for every stored operand.
    for (genvar i = 0; i < DEPTH; i++) begin : g_mem_snoop
        cdb_snoop u_src1 (
            .i_rdy  (r_mem[i].src1_rdy),
            .i_tag  (r_mem[i].src1_tag),
            .i_data (r_mem[i].src1_data),
            .i_cdb0 (cdb_port0),
            .i_cdb1 (cdb_port1),
            .o_rdy  (w_m_s1_rdy[i]),
            .o_data (w_m_s1_data[i])
        );
        cdb_snoop u_src2 (
            .i_rdy  (r_mem[i].src2_rdy),
            .i_tag  (r_mem[i].src2_tag),
            .i_data (r_mem[i].src2_data),
            .i_cdb0 (cdb_port0),
            .i_cdb1 (cdb_port1),
            .o_rdy  (w_m_s2_rdy[i]),
            .o_data (w_m_s2_data[i])
        );
    end

    // Wakeup for the ops being written this cycle.
    for (genvar j = 0; j < 2; j++) begin : g_enq_snoop
        cdb_snoop u_src1 (
            .i_rdy  (w_enq_raw[j].src1_rdy),
            .i_tag  (w_enq_raw[j].src1_tag),
            .i_data (w_enq_raw[j].src1_data),
            .i_cdb0 (cdb_port0),
            .i_cdb1 (cdb_port1),
            .o_rdy  (w_e_s1_rdy[j]),
            .o_data (w_e_s1_data[j])
        );
        cdb_snoop u_src2 (
            .i_rdy  (w_enq_raw[j].src2_rdy),
            .i_tag  (w_enq_raw[j].src2_tag),
            .i_data (w_enq_raw[j].src2_data),
            .i_cdb0 (cdb_port0),
            .i_cdb1 (cdb_port1),
            .o_rdy  (w_e_s2_rdy[j]),
            .o_data (w_e_s2_data[j])
        );
    end

    // Merge snooped operands back into full entries.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_snp_mem[i]           = r_mem[i];
            w_snp_mem[i].src1_rdy  = w_m_s1_rdy[i];
            w_snp_mem[i].src1_data = w_m_s1_data[i];
            w_snp_mem[i].src2_rdy  = w_m_s2_rdy[i];
            w_snp_mem[i].src2_data = w_m_s2_data[i];
        end
        for (int j = 0; j < 2; j++) begin
            w_enq_snp[j]           = w_enq_raw[j];
            w_enq_snp[j].valid     = 1'b1;
            w_enq_snp[j].src1_rdy  = w_e_s1_rdy[j];
            w_enq_snp[j].src1_data = w_e_s1_data[j];
            w_enq_snp[j].src2_rdy  = w_e_s2_rdy[j];
            w_enq_snp[j].src2_data = w_e_s2_data[j];
        end
    end

    // Two oldest entries to the RS array, carrying same-cycle CDB forwarding.
    always_comb begin
        rs_entry[0]       = w_snp_mem[w_rd_idx0];
        rs_entry[0].valid = (w_n_deq != 2'd0);
        rs_entry[1]       = w_snp_mem[w_rd_idx1];
        rs_entry[1].valid = (w_n_deq == 2'd2);
    end

    // Pointer and storage update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= w_snp_mem[i];
        end
        if (rst || flush) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            r_head <= r_head + CNT_W'(w_n_deq);
            r_tail <= r_tail + CNT_W'(w_enq_num);
            if (w_enq_num != 2'd0) begin
                r_mem[w_wr_idx0] <= w_enq_snp[0];
            end
            if (w_enq_num == 2'd2) begin
                r_mem[w_wr_idx1] <= w_enq_snp[1];
            end
        end
    end

`ifdef DQ_PERF_CNT_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_block;

    // Saturating occupancy counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full  <= '0;
            r_perf_block <= '0;
        end else begin
            if ((w_count == CNT_W'(DEPTH)) && (r_perf_full != 32'hFFFF_FFFF)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
            if ((w_count != '0) && (rs_rdy == 2'b00) && !cache_stall &&
                (r_perf_block != 32'hFFFF_FFFF)) begin
                r_perf_block <= r_perf_block + 32'd1;
            end
        end
    end

    assign perf_full_cycles     = r_perf_full;
    assign perf_rs_block_cycles = r_perf_block;
`endif

endmodule
